// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among N_REQ texel requesters.
// Optional SPRITE_ARB_PRIO0_EN: requester 0 always wins, round-robin among the rest.
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_sync,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

`ifdef SPRITE_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    localparam int PTR_W = $clog2(N_REQ);
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t              ptr;
    ptr_t              gnt_idx;
    logic              gnt_any;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ROM_LAT-1:0] tag_v;
    ptr_t              tag_id [ROM_LAT];

    always_comb begin
        ptr_t cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (PRIO0 && req_valid[0]) begin
            gnt_any = 1'b1;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = PTR_W'((32'(ptr) + k) % N_REQ);
                if (!gnt_any && req_valid[cand] && !(PRIO0 && cand == '0)) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    // Reset masks every output so nothing escapes while state is being cleared.
    assign grant    = gnt_any && !rst;
    assign rom_en   = grant;
    assign rom_addr = grant ? req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W] : addr_q;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (!rst && tag_v[ROM_LAT-1]) rsp_valid[tag_id[ROM_LAT-1]] = 1'b1;
    end

    assign rsp_data = (rsp_valid != '0) ? rom_data : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            addr_q <= '0;
            data_q <= '0;
            tag_v  <= '0;
            for (int unsigned k = 0; k < ROM_LAT; k++) tag_id[k] <= '0;
        end else begin
            addr_q   <= rom_addr;
            data_q   <= rsp_data;
            tag_v[0] <= grant;
            tag_id[0] <= gnt_idx;
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (frame_sync)
                ptr <= '0;
            else if (grant && !(PRIO0 && gnt_idx == '0))
                ptr <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share stimulus;
// a queue/array-based model checks every cycle, directed cases pin literal values.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst, frame_sync;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;

    logic [3:0]  ready1, ready3, rv1, rv3;
    logic        en1, en3;
    logic [7:0]  addr1, addr3;
    logic [11:0] rom1, rom3, rd1, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(12), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(ready1), .rom_en(en1), .rom_addr(addr1),
        .rom_data(rom1), .rsp_valid(rv1), .rsp_data(rd1));

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(8), .DATA_W(12), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(ready3), .rom_en(en3), .rom_addr(addr3),
        .rom_data(rom3), .rsp_valid(rv3), .rsp_data(rd3));

    // ROM: data = addr*3, delivered ROM_LAT cycles after the address.
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= addr1;
        pipe3[0] <= addr3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rom1 = 12'(pipe1) * 12'd3;
    assign rom3 = 12'(pipe3[2]) * 12'd3;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut_lat%0d actual=%h required=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

`ifdef SPRITE_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    // Model: rotating priority scan plus per-instance response slots keyed by due cycle.
    int          m_on = 0;
    int          m_ptr = 0;
    int          cyc = 0;
    logic [7:0]  m_last_addr = '0;
    logic [11:0] m_last_data [2] = '{12'h0, 12'h0};
    bit          pend_v [2][8];
    int          pend_id [2][8];
    logic [7:0]  pend_addr [2][8];
    int          lat [2] = '{1, 3};

    always @(negedge clk) begin
        int g;
        int i;
        int s;
        logic [7:0]  g_addr;
        logic [3:0]  e_ready, e_rv;
        logic [11:0] e_rd;
        logic [3:0]  a_ready [2];
        logic        a_en [2];
        logic [7:0]  a_addr [2];
        logic [3:0]  a_rv [2];
        logic [11:0] a_rd [2];
        a_ready = '{ready1, ready3};
        a_en    = '{en1, en3};
        a_addr  = '{addr1, addr3};
        a_rv    = '{rv1, rv3};
        a_rd    = '{rd1, rd3};

        g = -1;
        if (!rst) begin
            if (PRIO0 && req_valid[0]) g = 0;
            else begin
                for (int k = 0; k < 4; k++) begin
                    i = (m_ptr + k) % 4;
                    if (g < 0 && req_valid[i] && !(PRIO0 && i == 0)) g = i;
                end
            end
        end
        g_addr  = (g >= 0) ? req_addr[g*8 +: 8] : m_last_addr;
        e_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        s = cyc % 8;

        for (int d = 0; d < 2; d++) begin
            if (!rst && pend_v[d][s]) begin
                e_rv = 4'(1 << pend_id[d][s]);
                e_rd = 12'(pend_addr[d][s]) * 12'd3;
            end else begin
                e_rv = 4'b0000;
                e_rd = m_last_data[d];
            end
            if (m_on != 0) begin
                check("req_ready", lat[d], 32'(a_ready[d]), 32'(e_ready));
                check("rom_en",    lat[d], 32'(a_en[d]),    32'(g >= 0));
                check("rom_addr",  lat[d], 32'(a_addr[d]),  32'(g_addr));
                check("rsp_valid", lat[d], 32'(a_rv[d]),    32'(e_rv));
                check("rsp_data",  lat[d], 32'(a_rd[d]),    32'(e_rd));
            end
            pend_v[d][s] = 1'b0;
            m_last_data[d] = e_rd;
            if (g >= 0) begin
                pend_v[d][(cyc + lat[d]) % 8]    = 1'b1;
                pend_id[d][(cyc + lat[d]) % 8]   = g;
                pend_addr[d][(cyc + lat[d]) % 8] = g_addr;
            end
        end
        m_last_addr = g_addr;
        if (g >= 0 && !(PRIO0 && g == 0)) m_ptr = (g + 1) % 4;
        if (frame_sync) m_ptr = 0;

        if (rst) begin
            m_on = 1;
            m_ptr = 0;
            m_last_addr = '0;
            for (int d = 0; d < 2; d++) begin
                m_last_data[d] = '0;
                for (int k = 0; k < 8; k++) pend_v[d][k] = 1'b0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b1; frame_sync = 1'b0; req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_sync = 1'b0; req_valid = 4'hF; req_addr = 32'h0;
        @(negedge clk);
        check("rst_ready", 1, 32'(ready1), 32'h0);
        check("rst_en",    1, 32'(en1),    32'h0);
        tick(); tick();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check("rst_addr",  1, 32'(addr1), 32'h0);
        check("rst_rv",    3, 32'(rv3),   32'h0);
        check("rst_data",  3, 32'(rd3),   32'h0);

        // Single request, ROM_LAT=1
        tick();
        req_valid = 4'b0001; req_addr = 32'h0000_0025;
        @(negedge clk);
        check("t1_ready", 1, 32'(ready1), 32'h1);
        check("t1_addr",  1, 32'(addr1),  32'h25);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_rsp_valid", 1, 32'(rv1), 32'h1);
        check("t1_rsp_data",  1, 32'(rd1), 32'h06F);
        tick();

`ifndef SPRITE_ARB_PRIO0_EN
        // Continuous requests from all four
        reset_cycle();
        req_valid = 4'hF; req_addr = 32'h1122_3344;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_grant", 1, 32'(ready1), 32'(1 << (k % 4)));
            if (k > 0) check("t2_rsp", 1, 32'(rv1), 32'(1 << ((k - 1) % 4)));
            tick();
        end
`endif

        // Back-to-back grants 2 then 3, ROM_LAT=3
        reset_cycle();
        req_valid = 4'b0100; req_addr = 32'h5544_0000;
        @(negedge clk); check("t3_grant2", 3, 32'(ready3), 32'h4);
        tick();
        req_valid = 4'b1000;
        @(negedge clk); check("t3_grant3", 3, 32'(ready3), 32'h8);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("t3_rv_a", 3, 32'(rv3), 32'h4);
        check("t3_rd_a", 3, 32'(rd3), 32'h0CC);
        tick();
        @(negedge clk);
        check("t3_rv_b", 3, 32'(rv3), 32'h8);
        check("t3_rd_b", 3, 32'(rd3), 32'h0FF);
        tick();

        // Reset with responses in flight
        reset_cycle();
        req_valid = 4'b0010; req_addr = 32'hA0B0_C0D0;
        tick();
        req_valid = 4'b0100;
        tick();
        reset_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_quiet", 3, 32'(rv3), 32'h0);
            check("t4_quiet", 1, 32'(rv1), 32'h0);
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk); check("t4_first", 3, 32'(ready3), 32'h1);
        tick();

        // frame_sync re-seeds pointer
        reset_cycle();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF; frame_sync = 1'b1;
        @(negedge clk); check("t5_fs_grant", 1, 32'(ready1), PRIO0 ? 32'h1 : 32'h4);
        tick();
        frame_sync = 1'b0;
        @(negedge clk); check("t5_after", 1, 32'(ready1), 32'h1);
        tick();

`ifdef SPRITE_ARB_PRIO0_EN
        reset_cycle();
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); check("t6_prio0", 1, 32'(ready1), 32'h1);
            tick();
        end
        req_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("t6_rr", 1, 32'(ready1), 32'(2 << k));
            tick();
        end
`endif

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            frame_sync = ($urandom_range(0, 29) == 0);
            req_valid  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            req_addr   = $urandom;
            tick();
        end
        rst = 1'b0; frame_sync = 1'b0; req_valid = '0;
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
